// File: rtl/btn_color_sel_if.sv
// Button/color-select bundle between the raw push-buttons, the selector and the LED color mux.
interface btn_color_sel_if;
  logic [2:0] i_btn;
  logic [2:0] o_btn;
  logic [2:0] o_press;
  logic       o_changed;

  modport slave  (input  i_btn, output o_btn, output o_press, output o_changed);
  modport master (output i_btn, input  o_btn, input  o_press, input  o_changed);
endinterface

// File: rtl/btn_color_sel.sv
// Debounced three-button color selector (red > green > blue) with registered one-hot output.
// Optional macro BTN_TOGGLE_OFF_EN: pressing the already selected color clears the selection.
module btn_color_sel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = 20
) (
  input  logic            clk,
  input  logic            i_reset,
  btn_color_sel_if.slave  bus
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_stable;
  logic [2:0]        r_stable_d;
  logic [2:0]        r_press;
  logic [2:0]        r_sel;
  logic              r_changed;
  logic [NB_CNT-1:0] r_cnt [3];

  logic [2:0]        w_winner;
  logic [2:0]        w_sel_nxt;

  // stage 0: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // stage 1: per-button debounce; any break in the mismatch restarts the count
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + NB_CNT'(1);
        end
      end
    end
  end

  // stage 2: rising-edge detect on the debounced level
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable_d <= '0;
      r_press    <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
    end
  end

  always_comb begin
    w_winner  = 3'b000;
    w_sel_nxt = r_sel;
    if (r_press[2])      w_winner = 3'b100;
    else if (r_press[1]) w_winner = 3'b010;
    else if (r_press[0]) w_winner = 3'b001;
    if (w_winner != 3'b000) begin
`ifdef BTN_TOGGLE_OFF_EN
      w_sel_nxt = (w_winner == r_sel) ? 3'b000 : w_winner;
`else
      w_sel_nxt = w_winner;
`endif
    end
  end

  // stage 3: registered selection and change strobe
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sel     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_changed <= (w_sel_nxt != r_sel);
    end
  end

  assign bus.o_btn     = r_sel;
  assign bus.o_press   = r_press;
  assign bus.o_changed = r_changed;

endmodule

// File: doc/btn_color_sel.md
BTN_COLOR_SEL -- requirements
Module: btn_color_sel

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles (10 ms at 100 MHz) needed to accept a new button level; legal range 2..2^NB_CNT-1.
REQ-002 SHALL provide parameter NB_CNT, default 20, meaning width of each debounce counter.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_btn  input  3  raw asynchronous push-buttons; bit2=red, bit1=green, bit0=blue; 1=pressed.
REQ-006 SHALL have port o_btn  output  3  registered one-hot color select, or 000 for none; drives the i_btn input of the downstream LED color mux.
REQ-007 SHALL have port o_press  output  3  one-cycle pulse per debounced rising edge, per button.
REQ-008 SHALL have port o_changed  output  1  one-cycle pulse in the cycle o_btn takes a new value.

Function
REQ-009 SHALL pass each i_btn bit through a 2-flop synchronizer before any other logic.
REQ-010 SHALL keep per button a stable level and a counter: synced==stable -> counter cleared; synced!=stable -> counter increments.
REQ-011 SHALL flip stable and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 with synced!=stable, so the mismatch lasted DEBOUNCE_CYCLES cycles.
REQ-012 SHALL clear the counter on any cycle the mismatch is not held (glitch shorter than DEBOUNCE_CYCLES), leaving stable unchanged.
REQ-013 SHALL assert o_press[i] for exactly one cycle, the cycle after stable[i] goes 0->1; release (1->0) produces no pulse.
REQ-014 SHALL load o_btn on the edge following an o_press pulse; for a new level held from sampling edge t0, o_btn updates at edge t0+DEBOUNCE_CYCLES+3.
REQ-015 SHALL resolve simultaneous o_press bits by priority red > green > blue; only the winner is loaded.
REQ-016 SHALL hold o_btn unchanged while no press is pending, including across releases.
REQ-017 SHALL assert o_changed in the same cycle o_btn changes; a press of the already selected color (macro off) gives no o_changed.
REQ-018 SHALL keep o_btn one-hot or 000 at all times; never two bits set.
REQ-019 SHALL saturate nothing: counter never exceeds DEBOUNCE_CYCLES-1 by construction.

Reset
REQ-020 SHALL, while i_reset=0, force synchronizers, stable levels, counters, o_press, o_changed to 0 and o_btn to 000 asynchronously.
REQ-021 SHALL release reset synchronously in effect: first state change no earlier than the first rising clk edge after i_reset goes 1.
REQ-022 SHALL treat a button held through reset release as a new press, accepted after the full debounce time.
REQ-023 SHALL abort any in-progress debounce count on reset mid-operation, with no pulse emitted.

Configuration
REQ-024 SHALL recognise macro BTN_TOGGLE_OFF_EN.
REQ-025 SHALL, with BTN_TOGGLE_OFF_EN defined, clear o_btn to 000 and pulse o_changed when the winning press equals the currently selected color.
REQ-026 SHALL, without BTN_TOGGLE_OFF_EN, leave o_btn unchanged on a repeat press of the selected color.

Verification (bench uses DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-027 SHALL check reset: i_reset=0 with i_btn=111 -> o_btn=000, o_press=000, o_changed=0 throughout.
REQ-028 SHALL check clean press: i_btn 000->100 held 20 cycles -> o_btn=100 exactly 7 edges after first sampling edge, o_press=100 and o_changed=1 for one cycle each.
REQ-029 SHALL check glitch rejection: i_btn=010 for 3 cycles then 000 -> o_btn unchanged, no o_press, no o_changed.
REQ-030 SHALL check priority: i_btn 000->011 in one cycle, held -> o_btn=010; then i_btn 100 -> o_btn=100.
REQ-031 SHALL check repeat press of selected 001: macro off -> o_btn stays 001, o_changed=0; macro on -> o_btn=000, o_changed pulses once.
REQ-032 SHALL check reset mid-debounce: i_btn=100 for 2 cycles, i_reset pulse low, hold 100 -> o_btn=100 only after full 7-edge latency from release.
